// File: rtl/risc_v_mike_pkg.sv
`default_nettype none
// ============================================================================
// Module  : risc_v_mike_pkg
// Purpose : Shared types and constants for the RISC-V "mike" UART boot loader.
//           Holds the boot-loader state encoding and the frame sync byte.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package risc_v_mike_pkg;

  // Boot-loader sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_LOAD   = 3'd3,
    ST_FIN    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  // Byte that opens a load frame (from IDLE or ERR).
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage : risc_v_mike_pkg
`default_nettype wire

// File: rtl/risc_v_mike_boot_loader.sv
`default_nettype none
// ============================================================================
// Module  : risc_v_mike_boot_loader
// Purpose : Receives a program image over a byte stream and writes it into
//           instruction memory, holding the core in reset until the image is
//           complete.  Frame: A5, len_lo, len_hi (word count N), then N
//           little-endian 32-bit words.
// Ports   : clk        - clock, all state on the rising edge
//           rst        - asynchronous active-high reset
//           rx_byte    - received byte, qualified by rx_valid
//           rx_valid   - one-cycle strobe per received byte
//           imem_we    - instruction-memory write strobe, one cycle per word
//           imem_addr  - word address of the write
//           imem_wdata - write data
//           core_rst   - reset to the core, high until a load completes
//           load_done  - high after a successful load
//           load_err   - high while in the error state
// Revision: 1.0 - initial release
// ============================================================================
module risc_v_mike_boot_loader
  import risc_v_mike_pkg::*;
#(
  parameter int unsigned IMEM_ADDR_W    = 10,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_valid,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   core_rst,
  output logic                   load_done,
  output logic                   load_err
);

  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  // One extra bit so a full memory (N == 2**IMEM_ADDR_W) is counted without wrap.
  localparam int unsigned WCNT_W = IMEM_ADDR_W + 1;
  // Expiry is detected on the last idle clock of the window so that the
  // transition to ERR lands exactly TIMEOUT_CYCLES clocks after the last byte.
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [32:0]      MAX_WORDS = 33'd1 << IMEM_ADDR_W;

  state_e              state_q;
  logic [7:0]          len_lo_q;
  logic [15:0]         len_q;
  logic [WCNT_W-1:0]   word_idx_q;
  logic [1:0]          byte_idx_q;
  logic [23:0]         asm_q;
  logic [CNT_W-1:0]    to_cnt_q;
  logic                imem_we_q;
  logic [IMEM_ADDR_W-1:0] imem_addr_q;
  logic [31:0]         imem_wdata_q;
  logic                core_rst_q;
  logic                load_done_q;
  logic                load_err_q;

  // Combinational helpers feeding the sequencer.
  logic [15:0] len_d;
  logic [31:0] word_d;
  logic        last_word_d;
  logic        timeout_d;
  logic        too_long_d;

  always_comb begin
    len_d       = {rx_byte, len_lo_q};
    word_d      = {rx_byte, asm_q};
    last_word_d = ((33'(word_idx_q) + 33'd1) == 33'(len_q));
    // A byte arriving on the expiry clock wins over the timeout.
    timeout_d   = !rx_valid && (to_cnt_q == TO_LAST);
    too_long_d  = (33'(len_d) > MAX_WORDS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      len_lo_q     <= '0;
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      to_cnt_q     <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          to_cnt_q <= '0;
          if (rx_valid && (rx_byte == SYNC_BYTE)) begin
            state_q <= ST_LEN_LO;
          end
        end

        ST_LEN_LO: begin
          if (rx_valid) begin
            to_cnt_q <= '0;
            len_lo_q <= rx_byte;
            state_q  <= ST_LEN_HI;
          end else if (timeout_d) begin
            to_cnt_q   <= '0;
            load_err_q <= 1'b1;
            state_q    <= ST_ERR;
          end else begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
          end
        end

        ST_LEN_HI: begin
          if (rx_valid) begin
            to_cnt_q   <= '0;
            len_q      <= len_d;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            if (len_d == 16'd0) begin
              state_q <= ST_FIN;
            end else if (too_long_d) begin
              load_err_q <= 1'b1;
              state_q    <= ST_ERR;
            end else begin
              state_q <= ST_LOAD;
            end
          end else if (timeout_d) begin
            to_cnt_q   <= '0;
            load_err_q <= 1'b1;
            state_q    <= ST_ERR;
          end else begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
          end
        end

        ST_LOAD: begin
          if (rx_valid) begin
            to_cnt_q <= '0;
            if (byte_idx_q == 2'd3) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= word_idx_q[IMEM_ADDR_W-1:0];
              imem_wdata_q <= word_d;
              word_idx_q   <= word_idx_q + WCNT_W'(1);
              byte_idx_q   <= '0;
              if (last_word_d) begin
                state_q <= ST_FIN;
              end
            end else begin
              case (byte_idx_q)
                2'd0:    asm_q[7:0]   <= rx_byte;
                2'd1:    asm_q[15:8]  <= rx_byte;
                default: asm_q[23:16] <= rx_byte;
              endcase
              byte_idx_q <= byte_idx_q + 2'd1;
            end
          end else if (timeout_d) begin
            // Any partially assembled word is simply abandoned.
            to_cnt_q   <= '0;
            byte_idx_q <= '0;
            load_err_q <= 1'b1;
            state_q    <= ST_ERR;
          end else begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
          end
        end

        // Release the core one cycle after the final write strobe.
        ST_FIN: begin
          core_rst_q  <= 1'b0;
          load_done_q <= 1'b1;
          state_q     <= ST_DONE;
        end

        ST_DONE: begin
          to_cnt_q <= '0;
        end

        ST_ERR: begin
          to_cnt_q <= '0;
          if (rx_valid && (rx_byte == SYNC_BYTE)) begin
            load_err_q <= 1'b0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            state_q    <= ST_LEN_LO;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst   = core_rst_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule : risc_v_mike_boot_loader
`default_nettype wire

// File: tb/tb_risc_v_mike_boot_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_risc_v_mike_boot_loader
// Purpose : Directed self-checking bench for risc_v_mike_boot_loader, built
//           with a 4-word memory and a 100-clock inter-byte timeout.
// Revision: 1.0 - initial release
// ============================================================================
module tb_risc_v_mike_boot_loader;

  localparam int unsigned AW = 2;
  localparam int unsigned TO = 100;

  logic          clk;
  logic          rst;
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          load_done;
  logic          load_err;

  int total;
  int bad;
  int wr_total;
  int base;
  logic [31:0] log_addr [0:63];
  logic [31:0] log_data [0:63];

  risc_v_mike_boot_loader #(
    .IMEM_ADDR_W   (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_rst  (core_rst),
    .load_done (load_done),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe seen in the cycle before each rising edge.
  initial wr_total = 0;
  always @(posedge clk) begin
    if (imem_we === 1'b1) begin
      if (wr_total < 64) begin
        log_addr[wr_total] = 32'(imem_addr);
        log_data[wr_total] = imem_wdata;
      end
      wr_total = wr_total + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation ran past time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the byte is sampled at the next rising edge.
  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    rst      = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;

    // ---------------- reset state ----------------
    idle(2);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    rst = 1'b0;
    idle(1);

    // ---------------- two-word load ----------------
    base = wr_total;
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    chk("w0_we", 32'(imem_we), 32'd1);
    chk("w0_addr", 32'(imem_addr), 32'd0);
    chk("w0_data", imem_wdata, 32'h0000_0013);
    send(8'h93); send(8'h00); send(8'h10); send(8'h00);
    chk("w1_we", 32'(imem_we), 32'd1);
    chk("w1_addr", 32'(imem_addr), 32'd1);
    chk("w1_data", imem_wdata, 32'h0010_0093);
    chk("w1_core_rst_still_high", 32'(core_rst), 32'd1);
    chk("w1_done_still_low", 32'(load_done), 32'd0);
    idle(1);
    chk("fin_we_low", 32'(imem_we), 32'd0);
    chk("fin_core_rst_low", 32'(core_rst), 32'd0);
    chk("fin_done", 32'(load_done), 32'd1);
    chk("two_word_count", 32'(wr_total - base), 32'd2);
    // DONE ignores a new frame.
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    idle(2);
    chk("done_ignores_rx", 32'(wr_total - base), 32'd2);
    chk("done_stays", 32'(load_done), 32'd1);

    // ---------------- noise then zero-length frame ----------------
    do_reset();
    base = wr_total;
    send(8'h55); send(8'h12);
    send(8'hA5); send(8'h00); send(8'h00);
    chk("n0_fin_done_low", 32'(load_done), 32'd0);
    chk("n0_fin_core_rst", 32'(core_rst), 32'd1);
    idle(1);
    chk("n0_done", 32'(load_done), 32'd1);
    chk("n0_core_rst_low", 32'(core_rst), 32'd0);
    chk("n0_no_writes", 32'(wr_total - base), 32'd0);

    // ---------------- oversize length, then full memory ----------------
    do_reset();
    base = wr_total;
    send(8'hA5); send(8'h05); send(8'h00);
    chk("big_err", 32'(load_err), 32'd1);
    chk("big_core_rst", 32'(core_rst), 32'd1);
    send(8'h77);
    chk("err_ignores_other", 32'(load_err), 32'd1);
    send(8'hA5);
    chk("err_cleared_by_sync", 32'(load_err), 32'd0);
    send(8'h04); send(8'h00);
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i));
    chk("full_last_we", 32'(imem_we), 32'd1);
    chk("full_last_addr", 32'(imem_addr), 32'd3);
    chk("full_last_data", imem_wdata, 32'h1F1E_1D1C);
    idle(1);
    chk("full_done", 32'(load_done), 32'd1);
    chk("full_count", 32'(wr_total - base), 32'd4);
    chk("full_a0", log_addr[base],   32'd0);
    chk("full_d0", log_data[base],   32'h1312_1110);
    chk("full_a1", log_addr[base+1], 32'd1);
    chk("full_d1", log_data[base+1], 32'h1716_1514);
    chk("full_a2", log_addr[base+2], 32'd2);
    chk("full_d2", log_data[base+2], 32'h1B1A_1918);

    // ---------------- timeout with partial word ----------------
    do_reset();
    base = wr_total;
    send(8'hA5); send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    idle(99);
    chk("to_not_yet", 32'(load_err), 32'd0);
    idle(1);
    chk("to_err", 32'(load_err), 32'd1);
    chk("to_core_rst", 32'(core_rst), 32'd1);
    chk("to_no_write", 32'(wr_total - base), 32'd0);
    // Recovery frame: partial AA BB must not leak into the new word.
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("rec_data", imem_wdata, 32'h0403_0201);
    chk("rec_addr", 32'(imem_addr), 32'd0);
    idle(1);
    chk("rec_done", 32'(load_done), 32'd1);
    chk("rec_count", 32'(wr_total - base), 32'd1);

    // ---------------- async reset mid-load ----------------
    do_reset();
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    send(8'h01); send(8'h02);
    #3 rst = 1'b1;
    #1;
    chk("ar_core_rst", 32'(core_rst), 32'd1);
    chk("ar_we", 32'(imem_we), 32'd0);
    chk("ar_addr", 32'(imem_addr), 32'd0);
    chk("ar_wdata", imem_wdata, 32'd0);
    chk("ar_done", 32'(load_done), 32'd0);
    chk("ar_err", 32'(load_err), 32'd0);
    idle(1);
    rst = 1'b0;
    idle(1);
    base = wr_total;
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h44); send(8'h33); send(8'h22); send(8'h11);
    idle(1);
    chk("ar_fresh_count", 32'(wr_total - base), 32'd1);
    chk("ar_fresh_addr", log_addr[base], 32'd0);
    chk("ar_fresh_data", log_data[base], 32'h1122_3344);
    chk("ar_fresh_done", 32'(load_done), 32'd1);

    // ---------------- byte on the expiry clock ----------------
    do_reset();
    base = wr_total;
    send(8'hA5); send(8'h01); send(8'h00);
    idle(99);
    send(8'h0A);
    chk("edge_no_err", 32'(load_err), 32'd0);
    send(8'h0B); send(8'h0C); send(8'h0D);
    chk("edge_we", 32'(imem_we), 32'd1);
    chk("edge_data", imem_wdata, 32'h0D0C_0B0A);
    idle(1);
    chk("edge_done", 32'(load_done), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_risc_v_mike_boot_loader
`default_nettype wire

// File: doc/risc_v_mike_boot_loader.md
RISC_V_MIKE_BOOT_LOADER -- requirements
Module: risc_v_mike_boot_loader

Interface
REQ-001 SHALL have parameter IMEM_ADDR_W, default 10, word-address width of instruction memory.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, max idle clocks between bytes in LEN/LOAD.
REQ-003 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port rx_byte  input  8  received UART byte, valid only with rx_valid.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe per received byte.
REQ-007 SHALL have port imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-008 SHALL have port imem_addr  output  IMEM_ADDR_W  word address of the write.
REQ-009 SHALL have port imem_wdata  output  32  write data.
REQ-010 SHALL have port core_rst  output  1  active-high reset to the core; high until load completes.
REQ-011 SHALL have port load_done  output  1  level, high after a successful load.
REQ-012 SHALL have port load_err  output  1  level, high in error state.

Function
REQ-013 SHALL implement FSM states IDLE, LEN_LO, LEN_HI, LOAD, FIN, DONE, ERR.
REQ-014 IDLE: rx_valid with rx_byte==0xA5 -> LEN_LO; any other byte ignored; no timeout in IDLE.
REQ-015 LEN_LO/LEN_HI: capture 16-bit word count N little-endian (LO first).
REQ-016 After LEN_HI: N==0 -> FIN; N > 2**IMEM_ADDR_W -> ERR; else -> LOAD with word index 0, byte index 0.
REQ-017 LOAD: bytes assembled little-endian (first byte -> wdata[7:0], fourth -> [31:24]).
REQ-018 Fourth byte strobed at cycle t -> imem_we=1 at t+1 with imem_addr=word index, imem_wdata=assembled word; index then increments.
REQ-019 imem_we SHALL be high for exactly one cycle per word; never outside LOAD/FIN transitions.
REQ-020 Word counter SHALL be IMEM_ADDR_W+1 bits so N==2**IMEM_ADDR_W completes without wrap; imem_addr never wraps.
REQ-021 After the Nth write strobe, FSM in FIN for one cycle, then DONE; core_rst deasserts the cycle after the final imem_we (never same cycle).
REQ-022 DONE: core_rst=0, load_done=1; all further rx_valid ignored until rst.
REQ-023 Timeout: in LEN_LO, LEN_HI, LOAD, TIMEOUT_CYCLES consecutive clocks without rx_valid -> ERR; counter clears on every rx_valid and on state entry.
REQ-024 ERR: core_rst=1, load_err=1, imem_we=0; byte 0xA5 -> LEN_LO with load_err cleared, partial word discarded; other bytes ignored.
REQ-025 Partial word (1-3 bytes) at timeout SHALL NOT be written.
REQ-026 rx_valid on the same cycle the timeout counter expires: byte wins, no ERR.

Reset
REQ-027 On rst high (any time, incl. mid-LOAD): state=IDLE, core_rst=1, imem_we=0, imem_addr=0, imem_wdata=0, load_done=0, load_err=0, counters=0, asynchronously.
REQ-028 A write pending at reset assertion SHALL be dropped.

Structure
REQ-029 State enum typedef and sync constant 0xA5 SHALL live in risc_v_mike_pkg.
REQ-030 Single module, no sub-module; timeout counter is inline, width $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-031 Send A5, 02, 00, 13 00 00 00, 93 00 10 00 -> writes addr0=0x00000013, addr1=0x00100093; load_done=1; core_rst low one cycle after second imem_we.
REQ-032 Send 55, 12, A5, 00, 00 -> noise ignored, no imem_we, load_done=1 two cycles after last length byte.
REQ-033 IMEM_ADDR_W=2: A5, 05, 00 -> ERR, load_err=1, core_rst=1; then A5, 04, 00 + 16 bytes -> four writes addr0..3, load_done=1.
REQ-034 TIMEOUT_CYCLES=100: A5, 01, 00, AA BB, then silence -> load_err=1 exactly 100 clocks after BB, no imem_we.
REQ-035 rst asserted after 6 of 8 payload bytes -> all outputs at reset values immediately; fresh A5 01 00 + 4 bytes -> one write at addr0.
REQ-036 Byte strobed on the exact timeout-expiry cycle -> accepted, no ERR.
